// File: rtl/amo_rmw_unit.sv
// Atomic read-modify-write unit: LR/SC and AMO ops over a simple memory port.
// Optional LR/SC reservation tracking enabled by AMO_RMW_RESERVATION_EN.
package ariane_pkg;
  typedef enum logic [3:0] {
    AMO_NONE = 4'b0000,
    AMO_LR, AMO_SC, AMO_SWAP, AMO_ADD,
    AMO_AND, AMO_OR, AMO_XOR,
    AMO_MAX, AMO_MAXU, AMO_MIN, AMO_MINU
  } amo_t;

  typedef struct packed {
    logic        req;
    amo_t        amo_op;
    logic [1:0]  size;
    logic [63:0] operand_a;
    logic [63:0] operand_b;
  } amo_req_t;

  typedef struct packed {
    logic        ack;
    logic [63:0] result;
  } amo_resp_t;
endpackage

module amo_rmw_unit
  import ariane_pkg::*;
#(
  parameter int unsigned AddrWidth = 56,
  parameter int unsigned DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  amo_req_t             amo_req_i,
  output amo_resp_t            amo_resp_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [63:0]          mem_wdata_o,
  output logic [7:0]           mem_be_o,
  input  logic                 mem_rvalid_i,
  input  logic [63:0]          mem_rdata_i,
  input  logic                 resv_clr_i
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP
  } state_e;

  state_e               state_q, state_d;
  amo_t                 op_q, op_d;
  logic                 word_q, word_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [63:0]          opnd_q, opnd_d;
  logic [63:0]          old_q, old_d;
  logic [63:0]          result_q, result_d;
  logic [63:0]          a_val, b_val, new_val;
  logic                 resv_hit, resv_set;
  logic                 resv_kill, resv_wr;

  // 32-bit ops pick the lane by address bit 2 and sign-extend it
  function automatic logic [63:0] lane_ext(
    input logic [63:0] d, input logic hi, input logic w);
    logic [31:0] l;
    l = hi ? d[63:32] : d[31:0];
    return w ? {{32{l[31]}}, l} : d;
  endfunction

  // ALU: sign-extended 32-bit values keep both signed and unsigned order
  always_comb begin
    a_val = lane_ext(old_q, addr_q[2], word_q);
    b_val = word_q ? {{32{opnd_q[31]}}, opnd_q[31:0]} : opnd_q;
    new_val = b_val;
    case (op_q)
      AMO_ADD:  new_val = a_val + b_val;
      AMO_AND:  new_val = a_val & b_val;
      AMO_OR:   new_val = a_val | b_val;
      AMO_XOR:  new_val = a_val ^ b_val;
      AMO_MAX:  new_val = ($signed(a_val) > $signed(b_val)) ? a_val : b_val;
      AMO_MIN:  new_val = ($signed(a_val) < $signed(b_val)) ? a_val : b_val;
      AMO_MAXU: new_val = (a_val > b_val) ? a_val : b_val;
      AMO_MINU: new_val = (a_val < b_val) ? a_val : b_val;
      default:  new_val = b_val;
    endcase
  end

`ifdef AMO_RMW_RESERVATION_EN
  logic                 resv_valid_q, resv_valid_d;
  logic [AddrWidth-4:0] resv_addr_q, resv_addr_d;

  assign resv_hit = resv_valid_q && !resv_clr_i &&
    (resv_addr_q == amo_req_i.operand_a[AddrWidth-1:3]);

  // Reservation: set by LR, killed by any SC, snoop, or own write
  always_comb begin
    resv_valid_d = resv_valid_q;
    resv_addr_d  = resv_addr_q;
    if (resv_set) begin
      resv_valid_d = 1'b1;
      resv_addr_d  = addr_q[AddrWidth-1:3];
    end
    if (resv_clr_i || resv_kill ||
        (resv_wr && resv_addr_q == addr_q[AddrWidth-1:3]))
      resv_valid_d = 1'b0;
  end

  // Reservation register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resv_valid_q <= 1'b0;
      resv_addr_q  <= '0;
    end else begin
      resv_valid_q <= resv_valid_d;
      resv_addr_q  <= resv_addr_d;
    end
  end
`else
  logic unused_resv;
  assign resv_hit    = 1'b0;
  assign unused_resv = ^{resv_clr_i, resv_set, resv_kill, resv_wr};
`endif

  // Next-state and capture logic
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    word_d    = word_q;
    addr_d    = addr_q;
    opnd_d    = opnd_q;
    old_d     = old_q;
    result_d  = result_q;
    resv_set  = 1'b0;
    resv_kill = 1'b0;
    resv_wr   = 1'b0;
    case (state_q)
      IDLE: if (amo_req_i.req) begin
        op_d   = amo_req_i.amo_op;
        word_d = (amo_req_i.size == 2'b10);
        addr_d = amo_req_i.operand_a[AddrWidth-1:0];
        opnd_d = amo_req_i.operand_b;
        case (amo_req_i.amo_op)
          AMO_SC: begin
            resv_kill = 1'b1;
            if (resv_hit) state_d = WR_REQ;
            else begin
              result_d = 64'd1;
              state_d  = RESP;
            end
          end
          AMO_NONE: begin
            result_d = 64'd0;
            state_d  = RESP;
          end
          default: state_d = RD_REQ;
        endcase
      end
      RD_REQ: if (mem_gnt_i) state_d = RD_WAIT;
      RD_WAIT: if (mem_rvalid_i) begin
        old_d = mem_rdata_i;
        if (op_q == AMO_LR) begin
          result_d = lane_ext(mem_rdata_i, addr_q[2], word_q);
          resv_set = 1'b1;
          state_d  = RESP;
        end else begin
          state_d = WR_REQ;
        end
      end
      WR_REQ: if (mem_gnt_i) begin
        resv_wr = 1'b1;
        state_d = WR_WAIT;
      end
      WR_WAIT: if (mem_rvalid_i) begin
        result_d = (op_q == AMO_SC) ? 64'd0 :
                   lane_ext(old_q, addr_q[2], word_q);
        state_d  = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and operand registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      op_q     <= AMO_NONE;
      word_q   <= 1'b0;
      addr_q   <= '0;
      opnd_q   <= '0;
      old_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      word_q   <= word_d;
      addr_q   <= addr_d;
      opnd_q   <= opnd_d;
      old_q    <= old_d;
      result_q <= result_d;
    end
  end

  // Memory port and response outputs decoded from state
  always_comb begin
    mem_be_o = 8'h00;
    unique case (1'b1)
      (state_q == RD_REQ): mem_be_o = 8'hFF;
      (state_q == WR_REQ): mem_be_o = !word_q ? 8'hFF :
                                      (addr_q[2] ? 8'hF0 : 8'h0F);
      default: mem_be_o = 8'h00;
    endcase
  end

  assign mem_req_o   = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign mem_we_o    = (state_q == WR_REQ);
  assign mem_addr_o  = {addr_q[AddrWidth-1:3], 3'b000};
  assign mem_wdata_o = word_q ? {2{new_val[31:0]}} : new_val;

  assign amo_resp_o.ack    = (state_q == RESP);
  assign amo_resp_o.result = result_q;

  logic unused_ok;
  assign unused_ok = ^{amo_req_i.operand_a, addr_q[1:0],
                       DataWidth == 64};

endmodule

// File: tb/tb_amo_rmw_unit.sv
// Scoreboard bench for amo_rmw_unit with a one-cycle-latency memory model.
// Reservation scenarios follow AMO_RMW_RESERVATION_EN when defined.
module tb_amo_rmw_unit;
  import ariane_pkg::*;

  localparam int AW = 56;

  logic          clk = 1'b0;
  logic          rst;
  amo_req_t      req;
  amo_resp_t     resp;
  logic          mreq, mgnt, mwe, rvalid, rclr;
  logic [AW-1:0] maddr;
  logic [63:0]   mwdata, rdata;
  logic [7:0]    mbe;

  logic [63:0] mem [0:2047];
  int          nreq, nwr;
  logic [63:0] last_wdata;
  logic [7:0]  last_be;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  amo_rmw_unit #(.AddrWidth(AW), .DataWidth(64)) dut (
    .clk_i(clk), .rst_i(rst),
    .amo_req_i(req), .amo_resp_o(resp),
    .mem_req_o(mreq), .mem_gnt_i(mgnt),
    .mem_we_o(mwe), .mem_addr_o(maddr),
    .mem_wdata_o(mwdata), .mem_be_o(mbe),
    .mem_rvalid_i(rvalid), .mem_rdata_i(rdata),
    .resv_clr_i(rclr)
  );

  // Memory responder: rvalid one cycle after each grant
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= 1'b0;
      if (mreq && mgnt) begin
        rvalid <= 1'b1;
        rdata  <= mem[maddr[13:3]];
        nreq   <= nreq + 1;
        if (mwe) begin
          nwr        <= nwr + 1;
          last_wdata <= mwdata;
          last_be    <= mbe;
        end
      end
    end
  end

  initial begin
    nreq = 0;
    nwr = 0;
    last_wdata = '0;
    last_be = '0;
  end

  function automatic logic [63:0] merge(
    input logic [63:0] o, input logic [63:0] w, input logic [7:0] be);
    logic [63:0] r;
    r = o;
    for (int b = 0; b < 8; b++)
      if (be[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  // Reference: returns {new memory word, expected result}
  function automatic logic [127:0] ref_amo(input amo_t op,
    input logic [1:0] sz, input logic [63:0] a,
    input logic [63:0] old, input logic [63:0] b);
    logic [31:0] o32, b32, n32;
    logic [63:0] n64, nw, r;
    if (sz == 2'b10) begin
      o32 = a[2] ? old[63:32] : old[31:0];
      b32 = b[31:0];
      case (op)
        AMO_ADD:  n32 = o32 + b32;
        AMO_AND:  n32 = o32 & b32;
        AMO_OR:   n32 = o32 | b32;
        AMO_XOR:  n32 = o32 ^ b32;
        AMO_MAX:  n32 = ($signed(o32) > $signed(b32)) ? o32 : b32;
        AMO_MIN:  n32 = ($signed(o32) < $signed(b32)) ? o32 : b32;
        AMO_MAXU: n32 = (o32 > b32) ? o32 : b32;
        AMO_MINU: n32 = (o32 < b32) ? o32 : b32;
        default:  n32 = b32;
      endcase
      nw = a[2] ? {n32, old[31:0]} : {old[63:32], n32};
      r  = {{32{o32[31]}}, o32};
    end else begin
      case (op)
        AMO_ADD:  n64 = old + b;
        AMO_AND:  n64 = old & b;
        AMO_OR:   n64 = old | b;
        AMO_XOR:  n64 = old ^ b;
        AMO_MAX:  n64 = ($signed(old) > $signed(b)) ? old : b;
        AMO_MIN:  n64 = ($signed(old) < $signed(b)) ? old : b;
        AMO_MAXU: n64 = (old > b) ? old : b;
        AMO_MINU: n64 = (old < b) ? old : b;
        default:  n64 = b;
      endcase
      nw = n64;
      r  = old;
    end
    return {nw, r};
  endfunction

  task automatic issue(input amo_t op, input logic [1:0] sz,
    input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    req.req = 1'b1;
    req.amo_op = op;
    req.size = sz;
    req.operand_a = a;
    req.operand_b = b;
    @(posedge clk);
    #1 req.req = 1'b0;
  endtask

  task automatic wait_ack(output int lat, output logic [63:0] res,
    output bit to, output bit again);
    lat = 0; res = '0; to = 1'b1; again = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (resp.ack) begin
        lat = i; res = resp.result; to = 1'b0;
        break;
      end
    end
    if (!to) begin
      @(negedge clk);
      again = resp.ack;
    end
  endtask

  task automatic test_reset();
    req = '0; mgnt = 1'b1; rclr = 1'b0; rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++; if (mreq !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", mreq); end
    checks++; if (mwe !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", mwe); end
    checks++; if (mbe !== 8'h00) begin errors++; $display("FAIL rst_be got %h exp 00", mbe); end
    checks++; if (resp.ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", resp.ack); end
    checks++; if (resp.result !== 64'd0) begin errors++; $display("FAIL rst_res got %h exp 0", resp.result); end
  endtask

  task automatic test_amoadd_d();
    int lat, n0; logic [63:0] res, e; bit to, ag;
    mem[11'(64'h1000 >> 3)] = 64'd5;
    n0 = nreq;
    exp_q.push_back(64'd5);
    issue(AMO_ADD, 2'b11, 64'h1000, 64'd3);
    wait_ack(lat, res, to, ag);
    e = exp_q.pop_front();
    checks++; if (to) begin errors++; $display("FAIL add_timeout got none exp ack"); end
    checks++; if (res !== e) begin errors++; $display("FAIL add_res got %h exp %h", res, e); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL add_lat got %0d exp 5", lat); end
    checks++; if (ag !== 1'b0) begin errors++; $display("FAIL add_ack2 got %b exp 0", ag); end
    checks++; if (nreq - n0 !== 2) begin errors++; $display("FAIL add_nreq got %0d exp 2", nreq - n0); end
    checks++; if (last_wdata !== 64'd8) begin errors++; $display("FAIL add_wdata got %h exp 8", last_wdata); end
    checks++; if (last_be !== 8'hFF) begin errors++; $display("FAIL add_be got %h exp FF", last_be); end
  endtask

  task automatic test_amomax_w();
    int lat; logic [63:0] res, e; bit to, ag;
    mem[11'(64'h1000 >> 3)] = {32'hFFFF_FFFE, 32'h1122_3344};
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
    issue(AMO_MAX, 2'b10, 64'h1004, 64'd1);
    wait_ack(lat, res, to, ag);
    e = exp_q.pop_front();
    checks++; if (res !== e) begin errors++; $display("FAIL maxw_res got %h exp %h", res, e); end
    checks++; if (last_be !== 8'hF0) begin errors++; $display("FAIL maxw_be got %h exp F0", last_be); end
    checks++; if (last_wdata[63:32] !== 32'd1) begin errors++; $display("FAIL maxw_wdata got %h exp 1", last_wdata[63:32]); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL maxw_lat got %0d exp 5", lat); end
  endtask

  task automatic test_ops();
    amo_t ops [8] = '{AMO_SWAP, AMO_ADD, AMO_AND, AMO_OR,
                      AMO_XOR, AMO_MAX, AMO_MAXU, AMO_MIN};
    int lat, w0; logic [63:0] res, e, old, b, a, got;
    logic [127:0] rr; logic [1:0] sz; bit to, ag;
    for (int k = 0; k < 9; k++) begin
      for (int s = 0; s < 3; s++) begin
        amo_t op;
        op = (k == 8) ? AMO_MINU : ops[k];
        a  = 64'h4000 + ((s == 1) ? 64'd4 : 64'd0) + 64'(k * 8);
        sz = (s == 2) ? 2'b11 : 2'b10;
        old = {$urandom, $urandom};
        b   = {$urandom, $urandom};
        if (k[0]) b[31] = ~old[31];
        mem[a[13:3]] = old;
        rr = ref_amo(op, sz, a, old, b);
        exp_q.push_back(rr[63:0]);
        w0 = nwr;
        issue(op, sz, a, b);
        wait_ack(lat, res, to, ag);
        e = exp_q.pop_front();
        got = merge(old, last_wdata, last_be);
        checks++; if (res !== e) begin errors++; $display("FAIL op%0d_s%0d_res got %h exp %h", k, s, res, e); end
        checks++; if (got !== rr[127:64]) begin errors++; $display("FAIL op%0d_s%0d_mem got %h exp %h", k, s, got, rr[127:64]); end
        checks++; if (nwr - w0 !== 1 || lat !== 5) begin errors++; $display("FAIL op%0d_s%0d_flow got wr %0d lat %0d exp 1/5", k, s, nwr - w0, lat); end
      end
    end
  endtask

  task automatic test_lr_sc();
    int lat, n0; logic [63:0] res, e; bit to, ag;
    mem[11'(64'h2000 >> 3)] = 64'h1234;
    n0 = nreq;
    exp_q.push_back(64'h1234);
    issue(AMO_LR, 2'b11, 64'h2000, 64'd0);
    wait_ack(lat, res, to, ag);
    e = exp_q.pop_front();
    checks++; if (res !== e) begin errors++; $display("FAIL lr_res got %h exp %h", res, e); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL lr_lat got %0d exp 3", lat); end
    checks++; if (nreq - n0 !== 1) begin errors++; $display("FAIL lr_nreq got %0d exp 1", nreq - n0); end
`ifdef AMO_RMW_RESERVATION_EN
    n0 = nwr;
    exp_q.push_back(64'd0);
    issue(AMO_SC, 2'b11, 64'h2000, 64'd7);
    wait_ack(lat, res, to, ag);
    e = exp_q.pop_front();
    checks++; if (res !== e) begin errors++; $display("FAIL sc_ok_res got %h exp %h", res, e); end
    checks++; if (nwr - n0 !== 1 || last_wdata !== 64'd7) begin errors++; $display("FAIL sc_ok_wr got %0d/%h exp 1/7", nwr - n0, last_wdata); end
    n0 = nreq;
    exp_q.push_back(64'd1);
    issue(AMO_SC, 2'b11, 64'h2000, 64'd9);
    wait_ack(lat, res, to, ag);
    e = exp_q.pop_front();
    checks++; if (res !== e) begin errors++; $display("FAIL sc2_res got %h exp %h", res, e); end
    checks++; if (nreq - n0 !== 0) begin errors++; $display("FAIL sc2_nreq got %0d exp 0", nreq - n0); end
    exp_q.push_back(mem[11'(64'h2000 >> 3)]);
    issue(AMO_LR, 2'b11, 64'h2000, 64'd0);
    wait_ack(lat, res, to, ag);
    e = exp_q.pop_front();
    checks++; if (res !== e) begin errors++; $display("FAIL lr2_res got %h exp %h", res, e); end
    rclr = 1'b1;
    @(negedge clk);
    rclr = 1'b0;
`endif
    n0 = nreq;
    exp_q.push_back(64'd1);
    issue(AMO_SC, 2'b11, 64'h2000, 64'd7);
    wait_ack(lat, res, to, ag);
    e = exp_q.pop_front();
    checks++; if (res !== e) begin errors++; $display("FAIL scf_res got %h exp %h", res, e); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL scf_lat got %0d exp 1", lat); end
    checks++; if (nreq - n0 !== 0) begin errors++; $display("FAIL scf_nreq got %0d exp 0", nreq - n0); end
  endtask

  task automatic test_none();
    int lat, n0; logic [63:0] res, e; bit to, ag;
    n0 = nreq;
    exp_q.push_back(64'd0);
    issue(AMO_NONE, 2'b11, 64'h2000, 64'd5);
    wait_ack(lat, res, to, ag);
    e = exp_q.pop_front();
    checks++; if (res !== e) begin errors++; $display("FAIL none_res got %h exp %h", res, e); end
    checks++; if (lat !== 1 || nreq - n0 !== 0) begin errors++; $display("FAIL none_flow got lat %0d req %0d exp 1/0", lat, nreq - n0); end
  endtask

  task automatic test_gnt_stall();
    int lat; logic [63:0] res, e; bit to, ag;
    mem[11'(64'h5008 >> 3)] = 64'd10;
    mgnt = 1'b0;
    exp_q.push_back(64'd10);
    issue(AMO_ADD, 2'b11, 64'h5008, 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (mreq !== 1'b1 || maddr !== 56'h5008 || mbe !== 8'hFF || mwe !== 1'b0) begin errors++; $display("FAIL stall%0d got req %b addr %h be %h exp 1/5008/FF", i, mreq, maddr, mbe); end
    end
    mgnt = 1'b1;
    wait_ack(lat, res, to, ag);
    e = exp_q.pop_front();
    checks++; if (to || ag) begin errors++; $display("FAIL stall_ack got to %b again %b exp 0/0", to, ag); end
    checks++; if (res !== e) begin errors++; $display("FAIL stall_res got %h exp %h", res, e); end
    checks++; if (last_wdata !== 64'd11) begin errors++; $display("FAIL stall_wdata got %h exp 11", last_wdata); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [63:0] res, e; bit to, ag, seen;
    mem[11'(64'h3000 >> 3)] = 64'hAA;
    issue(AMO_SWAP, 2'b11, 64'h3000, 64'h55);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mreq && mwe) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rmid_wr got none exp write"); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (mreq !== 1'b0 || mwe !== 1'b0 || mbe !== 8'h00) begin errors++; $display("FAIL rmid_mem got %b/%b/%h exp 0/0/00", mreq, mwe, mbe); end
    checks++; if (resp.ack !== 1'b0 || resp.result !== 64'd0) begin errors++; $display("FAIL rmid_resp got %b/%h exp 0/0", resp.ack, resp.result); end
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(64'hAA);
    issue(AMO_ADD, 2'b11, 64'h3000, 64'd1);
    wait_ack(lat, res, to, ag);
    e = exp_q.pop_front();
    checks++; if (res !== e || lat !== 5) begin errors++; $display("FAIL rmid_next got %h lat %0d exp %h lat 5", res, lat, e); end
    checks++; if (last_wdata !== 64'hAB) begin errors++; $display("FAIL rmid_wdata got %h exp AB", last_wdata); end
  endtask

  initial begin
    test_reset();
    test_amoadd_d();
    test_amomax_w();
    test_ops();
    test_lr_sc();
    test_none();
    test_gnt_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/amo_rmw_unit.md
AMO_RMW_UNIT -- requirements
Module: amo_rmw_unit

Interface
REQ-001 SHALL have parameter AddrWidth, default 56: physical address width; operand_a bits above AddrWidth ignored.
REQ-002 SHALL have parameter DataWidth, default 64: memory data width; only 64 supported.
REQ-003 SHALL have port clk_i  input  1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_i  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port amo_req_i  input  ariane_pkg::amo_req_t: req, amo_op, size, operand_a (address), operand_b (store operand).
REQ-006 SHALL have port amo_resp_o  output  ariane_pkg::amo_resp_t: ack (1-cycle pulse) and result (64).
REQ-007 SHALL have port mem_req_o  output  1: memory request valid.
REQ-008 SHALL have port mem_gnt_i  input  1: request accepted this cycle.
REQ-009 SHALL have port mem_we_o  output  1: 1 = write, 0 = read.
REQ-010 SHALL have port mem_addr_o  output  AddrWidth: 8-byte-aligned address (bits [2:0] zero).
REQ-011 SHALL have port mem_wdata_o  output  64: write data, lane-positioned.
REQ-012 SHALL have port mem_be_o  output  8: byte enables.
REQ-013 SHALL have port mem_rvalid_i  input  1: read data or write completion, one per granted request.
REQ-014 SHALL have port mem_rdata_i  input  64: read data, valid with mem_rvalid_i.
REQ-015 SHALL have port resv_clr_i  input  1: external reservation kill (snoop/interrupt).

Function
REQ-016 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP.
REQ-017 IDLE with amo_req_i.req=1 SHALL capture op, size, address, operand and move to RD_REQ; amo_req_i ignored outside IDLE.
REQ-018 Exception: SC SHALL go from IDLE directly to WR_REQ if reservation valid and matching, else to RESP with result 1 and no memory access.
REQ-019 RD_REQ/WR_REQ SHALL hold mem_req_o=1 with stable addr/we/wdata/be until mem_gnt_i, then move to RD_WAIT/WR_WAIT.
REQ-020 RD_WAIT on mem_rvalid_i SHALL register the old value; LR then moves to RESP, all other ops to WR_REQ.
REQ-021 WR_WAIT on mem_rvalid_i SHALL move to RESP.
REQ-022 RESP SHALL assert amo_resp_o.ack for exactly one cycle and return to IDLE.
REQ-023 amo_resp_o.result SHALL be the old memory value (sign-extended from 32 bits for size 2'b10), 0 for successful SC, 1 for failed SC; held stable from RESP until the next RESP.
REQ-024 New value SHALL be: SWAP operand; ADD old+operand (wrapping); AND/OR/XOR bitwise; MAX/MIN signed compare; MAXU/MINU unsigned compare; SC operand.
REQ-025 Size 2'b10 SHALL compute on 32 bits, select lane by address bit 2, mem_be_o 8'h0F or 8'hF0; size 2'b11 SHALL use 8'hFF; reads use 8'hFF.
REQ-026 Address alignment SHALL NOT be checked; upstream guarantees natural alignment.
REQ-027 Minimum latency with mem_gnt_i tied 1 and rvalid one cycle after grant: RMW ack 5 cycles after capture, LR 3, failed SC 1.
REQ-028 AMO_NONE SHALL be treated as failed SC, with ack and result 0, no memory access.

Reset
REQ-029 Asynchronous rst_i SHALL force IDLE, mem_req_o=0, mem_we_o=0, mem_be_o=0, ack=0, result=0, reservation invalid, mid-operation included; a granted but outstanding access is abandoned.

Configuration
REQ-030 Macro AMO_RMW_RESERVATION_EN defined: LR sets reservation {valid, address[AddrWidth-1:3]}; any SC, resv_clr_i, or write from this unit to the reserved address clears it; resv_clr_i coincident with SC capture makes the SC fail.
REQ-031 Macro not defined: no reservation register, resv_clr_i unused, LR is a plain load, every SC fails (result 1, no write).

Verification
REQ-032 AMOADD.D at 0x1000, mem old 5, operand 3 -> read then write 8 with be 8'hFF, ack once, result 5.
REQ-033 AMOMAX.W at 0x1004, old 32'hFFFF_FFFE, operand 1 -> write 1 to be 8'hF0 lane, result 64'hFFFF_FFFF_FFFF_FFFE.
REQ-034 (EN) LR.D 0x2000 then SC.D 0x2000 data 7 -> SC writes 7, result 0; second SC -> no access, result 1.
REQ-035 (EN) LR.D 0x2000, pulse resv_clr_i, SC.D 0x2000 -> no memory request, ack after 1 cycle, result 1.
REQ-036 mem_gnt_i held low 4 cycles during RD_REQ -> address/be stable all 4 cycles, single ack at end.
REQ-037 rst_i asserted in WR_WAIT -> mem_req_o and ack 0 same cycle, FSM IDLE, next request serviced normally.
